// File: rtl/ascii_uart_tx.sv
// ascii_uart_tx: serialises a fixed-width ASCII buffer onto an 8N1 UART line.
// NUL bytes (converter padding) are skipped; optionally each record is closed
// with CR LF. One record is sent per accepted load; done pulses at the end.
module ascii_uart_tx #(
  parameter int BYTES        = 11,
  parameter int CLKS_PER_BIT = 868,
  parameter bit APPEND_CRLF  = 1'b1
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [0:BYTES*8-1]   ascii,
  input  logic                 load,
  output logic                 busy,
  output logic                 done,
  output logic                 tx
);

  localparam int BW = $clog2(CLKS_PER_BIT);
  localparam int IW = (BYTES > 1) ? $clog2(BYTES) : 1;
  localparam logic [BW-1:0] BAUD_LAST = BW'(CLKS_PER_BIT - 1);
  localparam logic [IW-1:0] IDX_LAST  = IW'(BYTES - 1);

  typedef enum logic [2:0] {
    IDLE,
    SCAN,
    START,
    DATA,
    STOP,
    CR,
    LF,
    FIN
  } state_t;

  // Origin of the character currently on the line; decides where STOP goes.
  typedef enum logic [1:0] {
    SRC_BUF,
    SRC_CR,
    SRC_LF
  } src_t;

  state_t             state;
  src_t               src;
  logic [BW-1:0]      baud_cnt;
  logic [2:0]         bit_cnt;
  logic [IW-1:0]      idx;
  logic [0:BYTES*8-1] buf_q;
  logic [7:0]         shreg;
  logic [7:0]         cur_byte;
  logic               baud_end;

  assign cur_byte = buf_q[{idx, 3'b000} +: 8];
  assign baud_end = (baud_cnt == BAUD_LAST);

  // Data path: buffer capture on accept, shift register load and LSB-first shifting.
  always_ff @(posedge clk) begin
    if (state == IDLE && load) begin
      buf_q <= ascii;
    end
    if (state == SCAN && cur_byte != 8'h00) begin
      shreg <= cur_byte;
    end else if (state == CR) begin
      shreg <= 8'h0D;
    end else if (state == LF) begin
      shreg <= 8'h0A;
    end else if (baud_end && (state == START || (state == DATA && bit_cnt != 3'd7))) begin
      shreg <= {1'b0, shreg[7:1]};
    end
  end

  // Control FSM: sequencing, baud/bit/index counters and registered tx/busy/done.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      src      <= SRC_BUF;
      baud_cnt <= '0;
      bit_cnt  <= '0;
      idx      <= '0;
      tx       <= 1'b1;
      busy     <= 1'b0;
      done     <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          tx       <= 1'b1;
          busy     <= 1'b0;
          done     <= 1'b0;
          baud_cnt <= '0;
          bit_cnt  <= '0;
          if (load) begin
            idx   <= '0;
            busy  <= 1'b1;
            state <= SCAN;
          end
        end
        SCAN: begin
          if (cur_byte == 8'h00) begin
            if (idx == IDX_LAST) begin
              if (APPEND_CRLF) state <= CR;
              else             state <= FIN;
            end else begin
              idx <= idx + IW'(1);
            end
          end else begin
            src      <= SRC_BUF;
            baud_cnt <= '0;
            tx       <= 1'b0;
            state    <= START;
          end
        end
        START: begin
          if (baud_end) begin
            baud_cnt <= '0;
            bit_cnt  <= '0;
            tx       <= shreg[0];
            state    <= DATA;
          end else begin
            baud_cnt <= baud_cnt + BW'(1);
          end
        end
        DATA: begin
          if (baud_end) begin
            baud_cnt <= '0;
            if (bit_cnt == 3'd7) begin
              bit_cnt <= '0;
              tx      <= 1'b1;
              state   <= STOP;
            end else begin
              bit_cnt <= bit_cnt + 3'd1;
              tx      <= shreg[0];
            end
          end else begin
            baud_cnt <= baud_cnt + BW'(1);
          end
        end
        STOP: begin
          if (baud_end) begin
            baud_cnt <= '0;
            case (src)
              SRC_CR:  state <= LF;
              SRC_LF:  state <= FIN;
              default: begin
                if (idx != IDX_LAST) begin
                  idx   <= idx + IW'(1);
                  state <= SCAN;
                end else if (APPEND_CRLF) begin
                  state <= CR;
                end else begin
                  state <= FIN;
                end
              end
            endcase
          end else begin
            baud_cnt <= baud_cnt + BW'(1);
          end
        end
        CR: begin
          src      <= SRC_CR;
          baud_cnt <= '0;
          tx       <= 1'b0;
          state    <= START;
        end
        LF: begin
          src      <= SRC_LF;
          baud_cnt <= '0;
          tx       <= 1'b0;
          state    <= START;
        end
        FIN: begin
          done  <= 1'b1;
          busy  <= 1'b0;
          tx    <= 1'b1;
          state <= IDLE;
        end
        default: begin
          tx    <= 1'b1;
          busy  <= 1'b0;
          done  <= 1'b0;
          state <= IDLE;
        end
      endcase
    end
  end

endmodule
